// File: rtl/countdown_sprite_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_sprite_ctrl
//
// Sequences the pre-round "3-2-1" countdown overlay. A start pulse walks the
// controller through the three digit sprites (three, two, one), each shown for
// FRAMES_PER_DIGIT frame ticks. In parallel, every clock the current VGA pixel
// coordinate is turned into a read address for the digit ROMs, and the active
// ROM's word is turned into a palette index plus an opaque/in-sprite flag that
// the colour mapper overlays on the playfield.
//
// Ports
//   Clk         in   system clock, all logic on the rising edge
//   Reset       in   synchronous, active-high reset
//   start       in   one-cycle pulse, begins a countdown when idle
//   abort       in   one-cycle pulse, cancels a running countdown
//   frame_tick  in   one-cycle pulse per frame
//   DrawX       in   current pixel column (10 bits)
//   DrawY       in   current pixel row (10 bits)
//   rom_addr    out  read address shared by all three digit ROMs (12 bits)
//   three_data  in   digit-three ROM word, one cycle after rom_addr
//   two_data    in   digit-two ROM word, one cycle after rom_addr
//   one_data    in   digit-one ROM word, one cycle after rom_addr
//   pix_idx     out  palette index of the overlay pixel
//   pix_valid   out  overlay pixel is inside the sprite and opaque
//   busy        out  countdown in progress
//   done        out  one-cycle pulse when a countdown completes normally
//
// Latency: DrawX/DrawY -> rom_addr 1 cycle, -> pix_idx/pix_valid 3 cycles.
// -----------------------------------------------------------------------------
module countdown_sprite_ctrl #(
  parameter int              SPRITE_W         = 60,
  parameter int              SPRITE_H         = 60,
  parameter int              X0               = 290,
  parameter int              Y0               = 210,
  parameter int              FRAMES_PER_DIGIT = 60,
  parameter int              DATA_W           = 5,
  parameter logic [DATA_W-1:0] TRANSPARENT    = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              abort,
  input  logic              frame_tick,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [11:0]       rom_addr,
  input  logic [DATA_W-1:0] three_data,
  input  logic [DATA_W-1:0] two_data,
  input  logic [DATA_W-1:0] one_data,
  output logic [DATA_W-1:0] pix_idx,
  output logic              pix_valid,
  output logic              busy,
  output logic              done
);

  // State encoding doubles as the ROM select code: 0 none, 1 three, 2 two,
  // 3 one. That lets stage 1 capture sel straight from the state register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW3 = 2'd1,
    SHOW2 = 2'd2,
    SHOW1 = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       done_n;
  logic       last_tick;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic in_region(input logic [9:0] x, input logic [9:0] y);
    return (x >= 10'(X0)) && (x < 10'(X0 + SPRITE_W)) &&
           (y >= 10'(Y0)) && (y < 10'(Y0 + SPRITE_H));
  endfunction

  // Only called for in-region pixels, so both offsets are small and the
  // 12-bit result stays within 0..SPRITE_W*SPRITE_H-1.
  function automatic logic [11:0] sprite_addr(input logic [9:0] x,
                                              input logic [9:0] y);
    logic [9:0] dx;
    logic [9:0] dy;
    dx = x - 10'(X0);
    dy = y - 10'(Y0);
    return 12'(dy) * 12'(SPRITE_W) + 12'(dx);
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [1:0]        sel,
                                             input logic [DATA_W-1:0] d3,
                                             input logic [DATA_W-1:0] d2,
                                             input logic [DATA_W-1:0] d1);
    logic [DATA_W-1:0] r;
    case (sel)
      2'd1:    r = d3;
      2'd2:    r = d2;
      2'd3:    r = d1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Countdown FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  // cnt never reaches FRAMES_PER_DIGIT, so cnt+1 cannot wrap in 8 bits.
  assign last_tick = frame_tick && ((cnt + 8'd1) == 8'(FRAMES_PER_DIGIT));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        // A tick arriving with start is not counted: the count starts at 0.
        if (start) begin
          state_n = SHOW3;
          cnt_n   = '0;
        end
      end
      default: begin
        // abort wins over a coinciding final tick, so no done pulse.
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (last_tick) begin
          cnt_n = '0;
          case (state)
            SHOW3:   state_n = SHOW2;
            SHOW2:   state_n = SHOW1;
            default: begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          endcase
        end else if (frame_tick) begin
          cnt_n = cnt + 8'd1;
        end
      end
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  logic [11:0]       addr_p0;
  logic              vld_p0;
  logic [1:0]        sel_p0;
  logic              vld_p1;
  logic [1:0]        sel_p1;
  logic [DATA_W-1:0] data_p1;
  logic [DATA_W-1:0] idx_p2;
  logic              vld_p2;
  logic              in_now;

  assign in_now  = in_region(DrawX, DrawY);
  assign data_p1 = pick(sel_p1, three_data, two_data, one_data);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_p0 <= '0;
      vld_p0  <= 1'b0;
      sel_p0  <= '0;
      vld_p1  <= 1'b0;
      sel_p1  <= '0;
      idx_p2  <= '0;
      vld_p2  <= 1'b0;
    end else begin
      // stage 1: address, region flag and digit select captured together
      addr_p0 <= in_now ? sprite_addr(DrawX, DrawY) : 12'd0;
      vld_p0  <= in_now;
      sel_p0  <= state;
      // stage 2: ROM read in flight; flag and select ride alongside it
      vld_p1  <= vld_p0;
      sel_p1  <= sel_p0;
      // stage 3: mux the selected ROM word and decide opacity
      idx_p2  <= data_p1;
      vld_p2  <= vld_p1 && (sel_p1 != 2'd0) && (data_p1 != TRANSPARENT);
    end
  end

  assign rom_addr  = addr_p0;
  assign pix_idx   = idx_p2;
  assign pix_valid = vld_p2;

endmodule

// File: tb/tb_countdown_sprite_ctrl.sv
module tb_countdown_sprite_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        abort;
  logic        frame_tick;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [11:0] rom_addr;
  logic [4:0]  three_data;
  logic [4:0]  two_data;
  logic [4:0]  one_data;
  logic [4:0]  pix_idx;
  logic        pix_valid;
  logic        busy;
  logic        done;

  int nvec  = 0;
  int nfail = 0;
  int rom_mode = 0;

  countdown_sprite_ctrl #(
    .SPRITE_W(60), .SPRITE_H(60), .X0(290), .Y0(210),
    .FRAMES_PER_DIGIT(2), .DATA_W(5), .TRANSPARENT(5'h00)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
    .frame_tick(frame_tick), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .three_data(three_data), .two_data(two_data),
    .one_data(one_data), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // ROM models with one-cycle registered read.
  // mode 0: every ROM returns addr[4:0]
  // mode 1: constant per digit (three=3, two=2, one=1)
  // mode 2: only two_data returns addr[4:0], the others return 31
  always @(posedge Clk) begin
    case (rom_mode)
      1: begin
        three_data <= 5'd3; two_data <= 5'd2; one_data <= 5'd1;
      end
      2: begin
        three_data <= 5'd31; two_data <= rom_addr[4:0]; one_data <= 5'd31;
      end
      default: begin
        three_data <= rom_addr[4:0]; two_data <= rom_addr[4:0];
        one_data <= rom_addr[4:0];
      end
    endcase
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; start = 1'b0; abort = 1'b0; frame_tick = 1'b0;
    step(); step();
    Reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
  endtask

  task automatic wait3();
    step(); step(); step();
  endtask

  typedef struct {
    int x;
    int y;
    int exp_addr;
    int exp_idx;
    int exp_valid;
  } vec_t;

  vec_t tbl[12];
  int   exp_q[12];
  int   dig;

  initial begin
    // Addressing vectors, applied in SHOW3 with ROM mode 0 (data = addr[4:0]).
    tbl[0]  = '{290, 210,    0,  0, 0};  // top-left corner, transparent word
    tbl[1]  = '{349, 269, 3599, 15, 1};  // bottom-right corner
    tbl[2]  = '{300, 215,  310, 22, 1};
    tbl[3]  = '{289, 210,    0,  0, 0};  // one column left of sprite
    tbl[4]  = '{350, 269,    0,  0, 0};  // one column right of sprite
    tbl[5]  = '{291, 210,    1,  1, 1};
    tbl[6]  = '{320, 240, 1830,  6, 1};
    tbl[7]  = '{290, 270,    0,  0, 0};  // one row below sprite
    tbl[8]  = '{290, 209,    0,  0, 0};  // one row above sprite
    tbl[9]  = '{  0,   0,    0,  0, 0};
    tbl[10] = '{349, 210,   59, 27, 1};  // top-right corner
    tbl[11] = '{290, 269, 3540, 20, 1};  // bottom-left corner

    DrawX = 10'd0; DrawY = 10'd0;

    // Reset state
    do_reset();
    chk("reset rom_addr", rom_addr, 0);
    chk("reset pix_idx", pix_idx, 0);
    chk("reset pix_valid", pix_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);

    // Table-driven addressing in SHOW3
    rom_mode = 0;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      DrawX = 10'(tbl[i].x); DrawY = 10'(tbl[i].y);
      step();
      chk($sformatf("vec%0d rom_addr", i), rom_addr, tbl[i].exp_addr);
      step(); step();
      chk($sformatf("vec%0d pix_idx", i), pix_idx, tbl[i].exp_idx);
      chk($sformatf("vec%0d pix_valid", i), pix_valid, tbl[i].exp_valid);
    end

    // Full countdown, FRAMES_PER_DIGIT = 2
    do_reset();
    rom_mode = 1; DrawX = 10'd300; DrawY = 10'd215;
    pulse_start();
    chk("cd busy after start", busy, 1);
    chk("cd done after start", done, 0);
    wait3();
    chk("cd digit initial", pix_idx, 3);
    for (int t = 1; t <= 6; t++) begin
      pulse_tick();
      chk($sformatf("cd done tick%0d", t), done, (t == 6) ? 1 : 0);
      chk($sformatf("cd busy tick%0d", t), busy, (t < 6) ? 1 : 0);
      dig = (t < 2) ? 3 : (t < 4) ? 2 : (t < 6) ? 1 : 0;
      wait3();
      chk($sformatf("cd digit tick%0d", t), pix_idx, dig);
      chk($sformatf("cd valid tick%0d", t), pix_valid, (dig != 0) ? 1 : 0);
      chk($sformatf("cd done after tick%0d", t), done, 0);
    end

    // Latency and mux: SHOW2, only two_data carries addr[4:0]
    do_reset();
    rom_mode = 2; DrawX = 10'd0; DrawY = 10'd0;
    pulse_start(); pulse_tick(); pulse_tick();
    wait3();
    DrawX = 10'd291; DrawY = 10'd210;
    step();
    chk("lat rom_addr", rom_addr, 1);
    chk("lat valid c1", pix_valid, 0);
    DrawX = 10'd0; DrawY = 10'd0;
    step();
    chk("lat valid c2", pix_valid, 0);
    step();
    chk("lat valid c3", pix_valid, 1);
    chk("lat idx c3", pix_idx, 1);
    step();
    chk("lat valid c4", pix_valid, 0);
    DrawX = 10'd290; DrawY = 10'd210;
    wait3();
    chk("transparent valid", pix_valid, 0);
    chk("transparent idx", pix_idx, 0);

    // start while in SHOW1 is ignored
    do_reset();
    rom_mode = 1; DrawX = 10'd300; DrawY = 10'd215;
    pulse_start();
    for (int t = 0; t < 4; t++) pulse_tick();
    pulse_start();
    wait3();
    chk("start in SHOW1 busy", busy, 1);
    chk("start in SHOW1 digit", pix_idx, 1);
    pulse_tick();
    chk("start in SHOW1 no early done", done, 0);
    pulse_tick();
    chk("start in SHOW1 done", done, 1);

    // abort in SHOW2
    do_reset();
    pulse_start(); pulse_tick(); pulse_tick();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    step();
    chk("abort done later", done, 0);
    step(); step();
    chk("abort digit", pix_idx, 0);
    chk("abort valid", pix_valid, 0);

    // abort in IDLE has no effect; abort + start together takes start
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort idle busy", busy, 0);
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    chk("abort+start busy", busy, 1);
    wait3();
    chk("abort+start digit", pix_idx, 3);

    // start + frame_tick in IDLE: tick not counted
    do_reset();
    start = 1'b1; frame_tick = 1'b1; step(); start = 1'b0; frame_tick = 1'b0;
    chk("start+tick busy", busy, 1);
    pulse_tick();
    wait3();
    chk("start+tick digit after 1 tick", pix_idx, 3);
    pulse_tick();
    wait3();
    chk("start+tick digit after 2 ticks", pix_idx, 2);

    // Mid-frame transition SHOW3 -> SHOW2 while pixels stream
    do_reset();
    pulse_start(); pulse_tick();
    for (int i = 0; i < 12; i++) begin
      DrawX = 10'(291 + i); DrawY = 10'd215;
      frame_tick = (i == 4);
      step();
      frame_tick = 1'b0;
      exp_q[i] = (i <= 4) ? 3 : 2;
      if (i >= 2) begin
        chk($sformatf("midframe px%0d idx", i - 2), pix_idx, exp_q[i-2]);
        chk($sformatf("midframe px%0d valid", i - 2), pix_valid, 1);
      end
    end

    // Reset during SHOW2 with in-region pixels
    do_reset();
    DrawX = 10'd300; DrawY = 10'd215;
    pulse_start(); pulse_tick(); pulse_tick();
    wait3();
    chk("pre-reset valid", pix_valid, 1);
    chk("pre-reset digit", pix_idx, 2);
    Reset = 1'b1;
    step();
    chk("midreset rom_addr", rom_addr, 0);
    chk("midreset pix_idx", pix_idx, 0);
    chk("midreset pix_valid", pix_valid, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    step();
    Reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("postreset valid c%0d", c), pix_valid, 0);
      chk($sformatf("postreset busy c%0d", c), busy, 0);
      chk($sformatf("postreset done c%0d", c), done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
